// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and load results into one register-file write port with per-source FIFOs and hazard lookup
module wb_arbiter #(
  parameter int REG_ADDR = 5,
  parameter int REG_SIZE = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [REG_ADDR-1:0] alu_reg,
  input  logic [REG_SIZE-1:0] alu_data,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [REG_ADDR-1:0] mem_reg,
  input  logic [REG_SIZE-1:0] mem_data,
  output logic                regwrite,
  output logic [REG_ADDR-1:0] wreg,
  output logic [REG_SIZE-1:0] wdata,
  input  logic [REG_ADDR-1:0] chk_reg,
  output logic                chk_pending
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic [REG_ADDR-1:0] q_reg [2][FIFO_DEPTH];
  logic [REG_SIZE-1:0] q_data [2][FIFO_DEPTH];
  logic [PW-1:0] wp [2];
  logic [PW-1:0] rp [2];
  logic [CW-1:0] cnt [2];
  logic [REG_ADDR-1:0] in_reg [2];
  logic [REG_SIZE-1:0] in_data [2];
  logic [1:0] vld, rdy, push, ne, pop_s;
  logic sel, pop, last_mem;
  assign in_reg[0] = alu_reg;
  assign in_reg[1] = mem_reg;
  assign in_data[0] = alu_data;
  assign in_data[1] = mem_data;
  assign vld = {mem_valid, alu_valid};
  assign alu_ready = rdy[0];
  assign mem_ready = rdy[1];
  always_comb begin
    rdy = '0;
    push = '0;
    ne = '0;
    for (int s = 0; s < 2; s++) begin
      rdy[s] = !reset && cnt[s] != CW'(FIFO_DEPTH);
      push[s] = vld[s] && rdy[s] && in_reg[s] != '0;
      ne[s] = cnt[s] != '0;
    end
    sel = &ne ? !last_mem : ne[1];
    pop = |ne;
    pop_s = !pop ? 2'b00 : sel ? 2'b10 : 2'b01;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        wp[s] <= '0;
        rp[s] <= '0;
        cnt[s] <= '0;
      end
      last_mem <= 1'b1;
      regwrite <= 1'b0;
      wreg <= '0;
      wdata <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) begin
          q_reg[s][wp[s]] <= in_reg[s];
          q_data[s][wp[s]] <= in_data[s];
          wp[s] <= wp[s] + 1'b1;
        end
        if (pop_s[s]) rp[s] <= rp[s] + 1'b1;
        cnt[s] <= cnt[s] + CW'(push[s]) - CW'(pop_s[s]);
      end
      regwrite <= pop;
      if (pop) begin
        wreg <= q_reg[sel][rp[sel]];
        wdata <= q_data[sel][rp[sel]];
        last_mem <= sel;
      end
    end
  end
  always_comb begin
    chk_pending = regwrite && wreg == chk_reg;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < FIFO_DEPTH; i++)
        if (CW'(i) < cnt[s] && q_reg[s][rp[s] + PW'(i)] == chk_reg) chk_pending = 1'b1;
    if (chk_reg == '0) chk_pending = 1'b0;
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: queue-based reference model with per-cycle compare plus directed literal checks
module tb_wb_arbiter;
  logic clk = 0;
  logic reset, alu_valid, mem_valid, regwrite, alu_ready, mem_ready, chk_pending;
  logic [4:0] alu_reg, mem_reg, wreg, chk_reg;
  logic [31:0] alu_data, mem_data, wdata;
  typedef struct {logic [4:0] r; logic [31:0] d;} ent_t;
  ent_t qa[$], qm[$];
  logic m_last = 1, m_rw = 0;
  logic [4:0] m_wreg = 0;
  logic [31:0] m_wdata = 0;
  int n_vec = 0, n_err = 0;
  int ord[4] = '{1, 5, 2, 6};
  always #5 clk = ~clk;
  wb_arbiter dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .regwrite(regwrite), .wreg(wreg), .wdata(wdata),
    .chk_reg(chk_reg), .chk_pending(chk_pending)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic m_pend();
    if (chk_reg == 0) return 0;
    if (m_rw && m_wreg == chk_reg) return 1;
    foreach (qa[i]) if (qa[i].r == chk_reg) return 1;
    foreach (qm[i]) if (qm[i].r == chk_reg) return 1;
    return 0;
  endfunction
  task automatic compare();
    check("alu_ready", alu_ready, 32'(!reset && qa.size() < 4));
    check("mem_ready", mem_ready, 32'(!reset && qm.size() < 4));
    check("chk_pending", chk_pending, 32'(m_pend()));
    check("regwrite", regwrite, 32'(m_rw));
    check("wreg", wreg, 32'(m_wreg));
    check("wdata", wdata, m_wdata);
  endtask
  task automatic model_step();
    logic ra, rm, sel;
    ent_t e;
    ra = !reset && qa.size() < 4;
    rm = !reset && qm.size() < 4;
    if (reset) begin
      qa.delete();
      qm.delete();
      m_rw = 0;
      m_wreg = 0;
      m_wdata = 0;
      m_last = 1;
      return;
    end
    m_rw = qa.size() > 0 || qm.size() > 0;
    if (m_rw) begin
      sel = (qa.size() > 0 && qm.size() > 0) ? !m_last : qm.size() > 0;
      e = sel ? qm.pop_front() : qa.pop_front();
      m_wreg = e.r;
      m_wdata = e.d;
      m_last = sel;
    end
    if (alu_valid && ra && alu_reg != 0) qa.push_back('{alu_reg, alu_data});
    if (mem_valid && rm && mem_reg != 0) qm.push_back('{mem_reg, mem_data});
  endtask
  task automatic cyc(input logic rs, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                     input logic mv, input logic [4:0] mr, input logic [31:0] md, input logic [4:0] cr);
    reset = rs;
    alu_valid = av;
    alu_reg = ar;
    alu_data = ad;
    mem_valid = mv;
    mem_reg = mr;
    mem_data = md;
    chk_reg = cr;
    #1;
    compare();
    model_step();
    @(negedge clk);
  endtask
  task automatic idle(input logic [4:0] cr);
    cyc(0, 0, 0, 0, 0, 0, 0, cr);
  endtask
  task automatic do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    reset = 1;
    alu_valid = 0;
    alu_reg = 0;
    alu_data = 0;
    mem_valid = 0;
    mem_reg = 0;
    mem_data = 0;
    chk_reg = 0;
    @(negedge clk);
    do_reset();
    check("rst_regwrite", regwrite, 0);
    check("rst_wreg", wreg, 0);
    check("rst_alu_ready", alu_ready, 0);
    check("rst_mem_ready", mem_ready, 0);
    cyc(0, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0);
    check("single_k", regwrite, 0);
    idle(0);
    check("single_rw", regwrite, 1);
    check("single_wreg", wreg, 3);
    check("single_wdata", wdata, 32'hDEADBEEF);
    idle(0);
    check("single_drop", regwrite, 0);
    check("single_hold", wreg, 3);
    do_reset();
    cyc(0, 1, 1, 32'h11, 1, 5, 32'h55, 0);
    cyc(0, 1, 2, 32'h22, 1, 6, 32'h66, 0);
    for (int i = 0; i < 4; i++) begin
      check("rr_rw", regwrite, 1);
      check("rr_wreg", wreg, 32'(ord[i]));
      idle(0);
    end
    check("rr_end", regwrite, 0);
    do_reset();
    for (int i = 1; i <= 6; i++) cyc(0, 1, 5'(i), 32'(i), 1, 5'(i + 10), 32'(i + 100), 0);
    check("full_mem_ready", mem_ready, 0);
    check("full_alu_ready", alu_ready, 1);
    cyc(0, 1, 7, 7, 1, 20, 32'h99, 0);
    check("full_alu_ready2", alu_ready, 0);
    check("full_mem_ready2", mem_ready, 1);
    cyc(0, 0, 0, 0, 1, 20, 32'h99, 0);
    repeat (12) idle(0);
    do_reset();
    cyc(0, 0, 0, 0, 1, 0, 32'h55, 0);
    check("r0_ready", mem_ready, 1);
    repeat (3) begin
      idle(0);
      check("r0_rw", regwrite, 0);
      check("r0_pend", chk_pending, 0);
    end
    do_reset();
    cyc(0, 1, 7, 32'h77, 0, 0, 0, 7);
    check("haz_q_pend", chk_pending, 1);
    idle(7);
    check("haz_rw", regwrite, 1);
    check("haz_wreg", wreg, 7);
    check("haz_w_pend", chk_pending, 1);
    idle(7);
    check("haz_clear", chk_pending, 0);
    do_reset();
    cyc(0, 1, 1, 1, 1, 2, 2, 0);
    cyc(0, 1, 3, 3, 1, 4, 4, 0);
    cyc(1, 1, 5, 5, 1, 6, 6, 0);
    check("mrst_alu_ready", alu_ready, 0);
    check("mrst_mem_ready", mem_ready, 0);
    check("mrst_rw", regwrite, 0);
    idle(0);
    check("mrst_alu_after", alu_ready, 1);
    check("mrst_mem_after", mem_ready, 1);
    repeat (3) begin
      check("mrst_no_write", regwrite, 0);
      idle(0);
    end
    repeat (800)
      cyc(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
